watch_ctrl_unit: RTL and testbench

- Control block for the stopwatch/watch counter chain (msec→sec→min→hour counters).
- Owns the shared 100 Hz tick prescaler and gates it separately into the stopwatch chain and the watch chain.
- Runs the stopwatch run/stop/clear FSM and the watch time-set FSM.
- Turns debounced button levels into single-cycle clear and increment pulses that drive the counters' tick, clear and button inputs.

---
 rtl/watch_ctrl_unit_if.sv | 29 ++
 rtl/watch_ctrl_unit.sv | 179 +++++++++++++++++
 tb/tb_watch_ctrl_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/watch_ctrl_unit_if.sv
// Button/mode inputs and counter-chain control outputs of the watch control unit.
// The master side is the button source; the slave side is the control unit.
interface watch_ctrl_unit_if;
    logic       sw_mode;
    logic       btn_l;
    logic       btn_r;
    logic       btn_u;
    logic       o_sw_tick;
    logic       o_sw_clear;
    logic       o_sw_running;
    logic       o_wt_tick;
    logic       o_inc_sec;
    logic       o_inc_min;
    logic       o_inc_hour;
    logic       o_edit;
    logic [1:0] o_field;

    modport master (
        output sw_mode, btn_l, btn_r, btn_u,
        input  o_sw_tick, o_sw_clear, o_sw_running, o_wt_tick,
        input  o_inc_sec, o_inc_min, o_inc_hour, o_edit, o_field
    );

    modport slave (
        input  sw_mode, btn_l, btn_r, btn_u,
        output o_sw_tick, o_sw_clear, o_sw_running, o_wt_tick,
        output o_inc_sec, o_inc_min, o_inc_hour, o_edit, o_field
    );
endinterface

// File: rtl/watch_ctrl_unit.sv
// Control unit for the stopwatch and watch counter chains: shared tick prescaler,
// stopwatch run/stop/clear FSM, watch time-set FSM and button edge detection.
module watch_ctrl_unit #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input logic              clk,
    input logic              reset,
    watch_ctrl_unit_if.slave bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    typedef enum logic [1:0] {
        SW_STOP  = 2'd0,
        SW_RUN   = 2'd1,
        SW_CLEAR = 2'd2
    } swState_t;

    typedef enum logic {
        W_RUN  = 1'b0,
        W_EDIT = 1'b1
    } wtState_t;

    logic [CNT_W-1:0] r_count;
    logic             r_prevL;
    logic             r_prevR;
    logic             r_prevU;
    logic             r_swTick;
    logic             r_wtTick;
    swState_t         r_swState;
    swState_t         w_swNext;
    wtState_t         r_wtState;
    wtState_t         w_wtNext;
    logic [1:0]       r_field;
    logic [1:0]       w_fieldNext;
    logic [2:0]       r_inc;
    logic [2:0]       w_incNext;

    logic w_term;
    logic w_edgeL;
    logic w_edgeR;
    logic w_edgeU;
    logic w_swL;
    logic w_swR;
    logic w_wtL;
    logic w_wtR;
    logic w_wtU;

    assign w_term  = (r_count == CNT_LAST);
    assign w_edgeL = bus.btn_l & ~r_prevL;
    assign w_edgeR = bus.btn_r & ~r_prevR;
    assign w_edgeU = bus.btn_u & ~r_prevU;

    // Edges are steered to one FSM only; the other mode's edges are dropped.
    assign w_swL = w_edgeL & ~bus.sw_mode;
    assign w_swR = w_edgeR & ~bus.sw_mode;
    assign w_wtL = w_edgeL &  bus.sw_mode;
    assign w_wtR = w_edgeR &  bus.sw_mode;
    assign w_wtU = w_edgeU &  bus.sw_mode;

    // Samples reset high so a button held through reset release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_prevL  <= 1'b1;
            r_prevR  <= 1'b1;
            r_prevU  <= 1'b1;
            r_swTick <= 1'b0;
            r_wtTick <= 1'b0;
        end else begin
            r_count  <= w_term ? '0 : r_count + CNT_W'(1);
            r_prevL  <= bus.btn_l;
            r_prevR  <= bus.btn_r;
            r_prevU  <= bus.btn_u;
            r_swTick <= w_term && (r_swState == SW_RUN);
            r_wtTick <= w_term && (r_wtState == W_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_swState <= SW_STOP;
        end else begin
            r_swState <= w_swNext;
        end
    end

    always_comb begin
        w_swNext = r_swState;
        case (r_swState)
            SW_STOP: begin
                if (w_swR) begin
                    w_swNext = SW_CLEAR;
                end else if (w_swL) begin
                    w_swNext = SW_RUN;
                end
            end
            SW_RUN: begin
                if (w_swL) begin
                    w_swNext = SW_STOP;
                end
            end
            default: w_swNext = SW_STOP;
        endcase
    end

    always_comb begin
        bus.o_sw_running = (r_swState == SW_RUN);
        bus.o_sw_clear   = (r_swState == SW_CLEAR);
        bus.o_sw_tick    = r_swTick;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wtState <= W_RUN;
            r_field   <= FIELD_SEC;
            r_inc     <= 3'b000;
        end else begin
            r_wtState <= w_wtNext;
            r_field   <= w_fieldNext;
            r_inc     <= w_incNext;
        end
    end

    // The increment targets the field as it was before any same-cycle advance.
    always_comb begin
        w_wtNext    = r_wtState;
        w_fieldNext = r_field;
        w_incNext   = 3'b000;
        case (r_wtState)
            W_RUN: begin
                if (w_wtL) begin
                    w_wtNext    = W_EDIT;
                    w_fieldNext = FIELD_SEC;
                end
            end
            W_EDIT: begin
                if (w_wtL) begin
                    w_wtNext    = W_RUN;
                    w_fieldNext = FIELD_SEC;
                end else begin
                    if (w_wtU) begin
                        case (r_field)
                            FIELD_MIN:  w_incNext = 3'b010;
                            FIELD_HOUR: w_incNext = 3'b100;
                            default:    w_incNext = 3'b001;
                        endcase
                    end
                    if (w_wtR) begin
                        case (r_field)
                            FIELD_SEC: w_fieldNext = FIELD_MIN;
                            FIELD_MIN: w_fieldNext = FIELD_HOUR;
                            default:   w_fieldNext = FIELD_SEC;
                        endcase
                    end
                end
            end
            default: begin
                w_wtNext    = W_RUN;
                w_fieldNext = FIELD_SEC;
            end
        endcase
    end

    always_comb begin
        bus.o_wt_tick  = r_wtTick;
        bus.o_edit     = (r_wtState == W_EDIT);
        bus.o_field    = r_field;
        bus.o_inc_sec  = r_inc[0];
        bus.o_inc_min  = r_inc[1];
        bus.o_inc_hour = r_inc[2];
    end
endmodule

// File: tb/tb_watch_ctrl_unit.sv
// Self-checking bench for watch_ctrl_unit: directed scenarios plus random button
// traffic, all compared every cycle against a behavioural model of the controls.
module tb_watch_ctrl_unit;
    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    watch_ctrl_unit_if bus();

    watch_ctrl_unit #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset release, stopwatch mode (0 stop, 1 run,
    // 2 clearing), edit flag, field index and the pending increment (-1 = none).
    int cyc;
    int swMode;
    bit editing;
    int field;
    int incField;
    bit prevL, prevR, prevU;
    bit expSwTick, expWtTick;

    int swTicksSeen, wtTicksSeen, clearsSeen, incsSeen;
    int incLog[$];

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        cyc       = 0;
        swMode    = 0;
        editing   = 1'b0;
        field     = 0;
        incField  = -1;
        prevL     = 1'b1;
        prevR     = 1'b1;
        prevU     = 1'b1;
        expSwTick = 1'b0;
        expWtTick = 1'b0;
    endfunction

    function automatic void modelStep();
        bit pressL, pressR, pressU, term, watchMode;
        pressL    = bus.btn_l && !prevL;
        pressR    = bus.btn_r && !prevR;
        pressU    = bus.btn_u && !prevU;
        watchMode = bus.sw_mode;
        term      = ((cyc % DIV) == DIV - 1);

        expSwTick = term && (swMode == 1);
        expWtTick = term && !editing;

        if (swMode == 2) begin
            swMode = 0;
        end else if (!watchMode) begin
            if (swMode == 0 && pressR)      swMode = 2;
            else if (swMode == 0 && pressL) swMode = 1;
            else if (swMode == 1 && pressL) swMode = 0;
        end

        incField = -1;
        if (watchMode) begin
            if (pressL) begin
                editing = !editing;
                field   = 0;
            end else if (editing) begin
                if (pressU) incField = field;
                if (pressR) field = (field + 1) % 3;
            end
        end

        prevL = bus.btn_l;
        prevR = bus.btn_r;
        prevU = bus.btn_u;
        cyc++;
    endfunction

    task automatic checkAll(input string where);
        checkOutput({where, ".sw_tick"},    bus.o_sw_tick,    expSwTick);
        checkOutput({where, ".sw_clear"},   bus.o_sw_clear,   swMode == 2);
        checkOutput({where, ".sw_running"}, bus.o_sw_running, swMode == 1);
        checkOutput({where, ".wt_tick"},    bus.o_wt_tick,    expWtTick);
        checkOutput({where, ".edit"},       bus.o_edit,       editing);
        checkOutput({where, ".field"},      bus.o_field,      field);
        checkOutput({where, ".inc_sec"},    bus.o_inc_sec,    incField == 0);
        checkOutput({where, ".inc_min"},    bus.o_inc_min,    incField == 1);
        checkOutput({where, ".inc_hour"},   bus.o_inc_hour,   incField == 2);
        checkOutput({where, ".inc_onehot"},
                    (32'(bus.o_inc_sec) + 32'(bus.o_inc_min) + 32'(bus.o_inc_hour)) <= 1, 1);
        checkOutput({where, ".tick_clear_excl"}, bus.o_sw_tick && bus.o_sw_clear, 0);
    endtask

    task automatic applyStimulus(input string where, input bit m, input bit l,
                                 input bit r, input bit u, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sw_mode = m;
            bus.btn_l   = l;
            bus.btn_r   = r;
            bus.btn_u   = u;
            @(posedge clk);
            modelStep();
            #1;
            checkAll(where);
            swTicksSeen += 32'(bus.o_sw_tick);
            wtTicksSeen += 32'(bus.o_wt_tick);
            clearsSeen  += 32'(bus.o_sw_clear);
            incsSeen    += 32'(bus.o_inc_sec) + 32'(bus.o_inc_min) + 32'(bus.o_inc_hour);
            if (bus.o_inc_sec)  incLog.push_back(1);
            if (bus.o_inc_min)  incLog.push_back(2);
            if (bus.o_inc_hour) incLog.push_back(3);
        end
    endtask

    task automatic clearSeen();
        swTicksSeen = 0;
        wtTicksSeen = 0;
        clearsSeen  = 0;
        incsSeen    = 0;
        incLog.delete();
    endtask

    // Called just after a rising edge; reset release lands mid-cycle.
    task automatic pulseReset(input string where);
        reset = 1'b0;
        modelReset();
        #1;
        checkAll(where);
        @(posedge clk);
        #3;
        checkAll(where);
        reset = 1'b1;
    endtask

    task automatic pressOnce(input string where, input bit m, input bit l,
                             input bit r, input bit u);
        applyStimulus(where, m, l, r, u, 1);
        applyStimulus(where, m, 1'b0, 1'b0, 1'b0, 1);
    endtask

    initial begin
        bit m, l, r, u;
        int expLog[4];
        bus.sw_mode = 1'b0;
        bus.btn_l   = 1'b0;
        bus.btn_r   = 1'b0;
        bus.btn_u   = 1'b0;
        clearSeen();
        @(posedge clk);
        #1;
        pulseReset("reset");

        $display("[TB] idle tick cadence");
        applyStimulus("idle", 1'b0, 1'b0, 1'b0, 1'b0, 25);
        checkOutput("idle.wt_ticks", wtTicksSeen, 2);
        checkOutput("idle.sw_ticks", swTicksSeen, 0);

        $display("[TB] stopwatch run then stop");
        clearSeen();
        applyStimulus("sw_start", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus("sw_run", 1'b0, 1'b0, 1'b0, 1'b0, 35);
        applyStimulus("sw_stop", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("sw_run.ticks_3or4", (swTicksSeen == 3) || (swTicksSeen == 4), 1);
        clearSeen();
        applyStimulus("sw_after", 1'b0, 1'b0, 1'b0, 1'b0, 20);
        checkOutput("sw_after.ticks", swTicksSeen, 0);

        $display("[TB] simultaneous run and clear");
        clearSeen();
        applyStimulus("sw_clear", 1'b0, 1'b1, 1'b1, 1'b0, 1);
        applyStimulus("sw_clear", 1'b0, 1'b0, 1'b0, 1'b0, 4);
        checkOutput("sw_clear.pulses", clearsSeen, 1);

        $display("[TB] watch edit sequence");
        clearSeen();
        pressOnce("edit", 1'b1, 1'b1, 1'b0, 1'b0);
        pressOnce("edit", 1'b1, 1'b0, 1'b0, 1'b1);
        pressOnce("edit", 1'b1, 1'b0, 1'b1, 1'b0);
        pressOnce("edit", 1'b1, 1'b0, 1'b0, 1'b1);
        pressOnce("edit", 1'b1, 1'b0, 1'b0, 1'b1);
        pressOnce("edit", 1'b1, 1'b0, 1'b1, 1'b0);
        pressOnce("edit", 1'b1, 1'b0, 1'b1, 1'b0);
        pressOnce("edit", 1'b1, 1'b0, 1'b0, 1'b1);
        pressOnce("edit", 1'b1, 1'b1, 1'b0, 1'b0);
        expLog = '{1, 2, 2, 1};
        checkOutput("edit.inc_count", incLog.size(), 4);
        for (int i = 0; i < 4 && i < incLog.size(); i++) begin
            checkOutput($sformatf("edit.inc_order%0d", i), incLog[i], expLog[i]);
        end
        checkOutput("edit.field_exit", bus.o_field, 0);

        $display("[TB] stopwatch keeps running in watch mode");
        pressOnce("cross", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("cross", 1'b1, 1'b1, 1'b0, 1'b0, 1);
        clearSeen();
        applyStimulus("cross", 1'b1, 1'b0, 1'b0, 1'b0, 30);
        checkOutput("cross.sw_ticks", swTicksSeen, 3);
        checkOutput("cross.wt_ticks", wtTicksSeen, 0);
        checkOutput("cross.running", bus.o_sw_running, 1);

        $display("[TB] held increment and reset mid-hold");
        clearSeen();
        applyStimulus("hold", 1'b1, 1'b0, 1'b0, 1'b1, 50);
        checkOutput("hold.incs", incsSeen, 1);
        applyStimulus("hold", 1'b1, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus("hold", 1'b1, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("hold.pulse_before_reset", bus.o_inc_sec, 1);
        bus.btn_l = 1'b1;
        pulseReset("hold_reset");
        clearSeen();
        applyStimulus("hold_release", 1'b1, 1'b1, 1'b0, 1'b1, 15);
        checkOutput("hold_release.incs", incsSeen, 0);
        checkOutput("hold_release.edit", bus.o_edit, 0);

        $display("[TB] random traffic");
        m = 1'b0; l = 1'b0; r = 1'b0; u = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) m = ~m;
            if ($urandom_range(0, 5) == 0)  l = ~l;
            if ($urandom_range(0, 4) == 0)  r = ~r;
            if ($urandom_range(0, 3) == 0)  u = ~u;
            if (i == 700) pulseReset("rand_reset");
            applyStimulus("rand", m, l, r, u, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
